tiny_nn_out_pack: RTL and testbench
===================================

Name: tiny_nn_out_pack

Overview:
- Downstream of the tiny_nn top-level accelerator.
- Consumes its 8-bit result byte stream, where each fp_t result appears as a low byte followed by a high byte.
- Reassembles the byte pairs into 16-bit fp_t words and buffers them in a small FIFO behind a valid/ready interface, for the host-side readout logic.
- The host asserts byte_valid_i on the cycles where the accelerator drives result bytes.

Parameters:
- Depth, 4, FIFO depth in fp_t words; power of two, at least 2.
- LevelWidth, $clog2(Depth+1), width of the fill-level output; derived, not overridden.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset
- clear_i  input  1  synchronous flush: empties FIFO, drops a held low byte, clears sticky flags
- byte_valid_i  input  1  byte_i carries a result byte this cycle
- byte_i  input  8  result byte from the accelerator's data_o
- word_valid_o  output  1  word_o holds a valid buffered word
- word_ready_i  input  1  consumer accepts word_o this cycle
- word_o  output  16  fp_t word, {high byte, low byte}
- level_o  output  LevelWidth  number of words currently in the FIFO
- half_word_o  output  1  low byte held, waiting for its high byte
- overflow_o  output  1  sticky: a completed word was dropped because the FIFO was full
- nan_seen_o  output  1  sticky NaN flag; see Optional Feature

Behaviour:
- Clock and reset:
  - One clock, clk_i.
  - Reset rst_ni is asynchronous and active-low.
  - Reset values: word_valid_o=0, word_o=0, level_o=0, half_word_o=0, overflow_o=0, nan_seen_o=0.
  - FIFO read/write pointers are 0 and the packer is in PkLow after reset.
  - Reset asserted mid-word discards the held low byte and all FIFO contents.
- Packer FSM, two states:
  - PkLow: byte_valid_i=1 captures byte_i into the low register and moves to PkHigh.
  - PkHigh: half_word_o=1. byte_valid_i=1 forms word {byte_i, low_q}, attempts a FIFO push, and returns to PkLow.
  - byte_valid_i=0 holds the current state indefinitely; there is no timeout.
- Push rules:
  - A push occurs in the cycle the high byte is accepted.
  - If the FIFO is full and no pop happens that cycle, the word is discarded, overflow_o is set next cycle, and the FSM still returns to PkLow.
  - If the FIFO is full and a pop happens the same cycle, the push is accepted and level_o is unchanged.
- Pop rules:
  - A pop occurs when word_valid_o && word_ready_i.
  - word_ready_i while empty has no effect.
  - word_o is the head entry. It is 0 when empty and must not be treated as data without word_valid_o.
- Latency and throughput:
  - High byte accepted in cycle N with the FIFO empty → word_valid_o=1 and word_o valid in cycle N+1.
  - There is no combinational path from byte_i to word_o.
  - Sustained throughput is one word per two byte_valid_i cycles.
- level_o:
  - Increments by 1 on push only, decrements by 1 on pop only, and is unchanged on a simultaneous push+pop.
  - Range is 0..Depth. word_valid_o = (level_o != 0).
- Pointers:
  - log2(Depth) bits, wrapping naturally.
  - Full/empty is decided by level_o, not by pointer equality.
- clear_i:
  - Has priority over byte_valid_i and pop in the same cycle.
  - The byte presented with clear_i is ignored.
  - Next cycle: level_o=0, word_valid_o=0, PkLow, overflow_o=0, nan_seen_o=0.
- Sticky flags: overflow_o and nan_seen_o are cleared only by clear_i or reset.

Optional Feature:
- Macro TINY_NN_OUT_PACK_NAN_FLAG_EN.
- Defined:
  - nan_seen_o is set the cycle after a packed word equal to FPStdNaN is completed.
  - This applies whether the word is pushed or dropped.
  - FPStdNaN is the end-of-stream marker constant from the package.
- Undefined:
  - nan_seen_o is tied to 0.
  - No comparator or flag register is built.

Decomposition:
- Shared package tiny_nn_pkg, reused as is:
  - fp_t.
  - FPStdNaN.
- Shared package tiny_nn_pkg, new additions:
  - The packer state enum pack_state_e (PkLow, PkHigh).
  - A default-depth constant OutPackDepth = 4.
- One sub-module, tiny_nn_fifo:
  - Parameterised width and depth, synchronous push/pop, level output, storage in flops.
  - Push-when-full with a simultaneous pop is allowed.
- The packer FSM, sticky flags and optional NaN logic stay in tiny_nn_out_pack.

Test Plan:
- Reset, then byte_valid_i with bytes 0x34, 0x12, word_ready_i=0 → half_word_o=1 after the first byte; word_valid_o=1, word_o=0x1234, level_o=1 one cycle after the second byte.
- Push 4 words 0x0001..0x0004 with word_ready_i=0, then a 5th pair 0xAA, 0xBB → level_o stays 4, overflow_o=1; draining yields 0x0001..0x0004 in order, then word_valid_o=0.
- With the FIFO full, complete a word 0x5678 in the same cycle word_ready_i=1 → 0x0001 popped, level_o stays 4, overflow_o stays 0, and 0x5678 is last out.
- Byte 0x34 followed by clear_i together with byte 0x12 → next cycle half_word_o=0, level_o=0, flags 0; then bytes 0x78, 0x56 → word_o=0x5678.
- Byte 0xCD, reset pulsed low, then bytes 0x01, 0x02 → word_o=0x0201, proving the pre-reset low byte was discarded.
- Complete a word equal to FPStdNaN → with TINY_NN_OUT_PACK_NAN_FLAG_EN, nan_seen_o=1 next cycle and held until clear_i; without the macro, nan_seen_o=0 throughout.

Source files
------------

// File: rtl/tiny_nn_pkg.sv
// tiny_nn_pkg: shared types and constants for the tiny_nn accelerator family.
// Contents:
//   fp_t          16-bit result word type
//   FPStdNaN      end-of-stream marker value
//   pack_state_e  states of the output byte packer (PkLow, PkHigh)
//   OutPackDepth  default FIFO depth of the output packer, in fp_t words
package tiny_nn_pkg;

    typedef logic [15:0] fp_t;

    localparam fp_t FPStdNaN = 16'h7E00;

    typedef enum logic {
        PkLow  = 1'b0,
        PkHigh = 1'b1
    } pack_state_e;

    localparam int OutPackDepth = 4;

endpackage

// File: rtl/tiny_nn_out_pack_if.sv
// tiny_nn_out_pack_if: byte-in / word-out stream bundle of the output packer.
// Signals:
//   byte_valid_i  byte_i carries a result byte this cycle
//   byte_i        result byte from the accelerator (low byte first, then high)
//   word_valid_o  word_o holds a valid buffered word
//   word_ready_i  consumer accepts word_o this cycle
//   word_o        reassembled fp_t word {high byte, low byte}
// Modports:
//   slave   the packer side (consumes bytes, produces words)
//   master  the environment side (produces bytes, consumes words)
interface tiny_nn_out_pack_if;
    import tiny_nn_pkg::*;

    logic       byte_valid_i;
    logic [7:0] byte_i;
    logic       word_valid_o;
    logic       word_ready_i;
    fp_t        word_o;

    modport slave (
        input  byte_valid_i,
        input  byte_i,
        input  word_ready_i,
        output word_valid_o,
        output word_o
    );

    modport master (
        output byte_valid_i,
        output byte_i,
        output word_ready_i,
        input  word_valid_o,
        input  word_o
    );

endinterface

// File: rtl/tiny_nn_fifo.sv
// tiny_nn_fifo: small flop-based synchronous FIFO with a fill-level output.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous flush, wins over push and pop
//   push_i/wdata_i  write request and data
//   pop_i           read request (ignored while empty)
//   rdata_o         head entry, 0 while empty
//   level_o         number of stored entries, 0..Depth
//   full_o          level_o == Depth
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
// Full/empty come from the level counter, so pointers simply wrap.
module tiny_nn_fifo #(
    parameter int Width = 16,
    parameter int Depth = 4,
    localparam int PtrW   = $clog2(Depth),
    localparam int LevelW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [Width-1:0]  wdata_i,
    input  logic              pop_i,
    output logic [Width-1:0]  rdata_o,
    output logic [LevelW-1:0] level_o,
    output logic              full_o
);

    logic [Width-1:0]  mem_q [Depth];
    logic [Width-1:0]  mem_d [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0] level_q, level_d;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign empty   = (level_q == '0);
    assign full_o  = (level_q == LevelW'(Depth));
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full_o || do_pop);

    // Next-state for storage, pointers and level; clear overrides everything.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                level_d = level_q + LevelW'(1);
            end else if (do_pop && !do_push) begin
                level_d = level_q - LevelW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Mask the head so stale storage never shows on the output when empty.
    assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/tiny_nn_out_pack.sv
// tiny_nn_out_pack: reassembles the accelerator's low/high result byte stream
// into fp_t words and buffers them in a small FIFO for host readout.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clear_i        synchronous flush: FIFO, held low byte and sticky flags
//   bus            tiny_nn_out_pack_if.slave (byte input, word valid/ready output)
//   level_o        words currently buffered
//   half_word_o    low byte held, waiting for its high byte
//   overflow_o     sticky: a completed word was dropped on a full FIFO
//   nan_seen_o     sticky: a completed word equalled FPStdNaN
// Build option: define TINY_NN_OUT_PACK_NAN_FLAG_EN to build the NaN detector;
// without it nan_seen_o is constant 0.
module tiny_nn_out_pack
    import tiny_nn_pkg::*;
#(
    parameter int Depth = OutPackDepth,
    localparam int LevelWidth = $clog2(Depth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    tiny_nn_out_pack_if.slave     bus,
    output logic [LevelWidth-1:0] level_o,
    output logic                  half_word_o,
    output logic                  overflow_o,
    output logic                  nan_seen_o
);

    pack_state_e state_q, state_d;
    logic [7:0]  low_q, low_d;
    logic        overflow_q, overflow_d;
    logic        high_accept;
    logic        push;
    logic        pop;
    logic        fifo_full;
    fp_t         packed_word;
    fp_t         fifo_rdata;
    logic [LevelWidth-1:0] fifo_level;

    assign packed_word = {bus.byte_i, low_q};
    assign high_accept = !clear_i && bus.byte_valid_i && (state_q == PkHigh);
    assign push        = high_accept;
    assign pop         = bus.word_valid_o && bus.word_ready_i && !clear_i;

    // Packer: hold the low byte, then push {high, low} when the high byte arrives.
    // A word completing on a full FIFO without a same-cycle pop is dropped and
    // flagged, but the packer still returns to PkLow so byte alignment is kept.
    always_comb begin
        state_d    = state_q;
        low_d      = low_q;
        overflow_d = overflow_q;
        if (clear_i) begin
            state_d    = PkLow;
            overflow_d = 1'b0;
        end else if (bus.byte_valid_i) begin
            if (state_q == PkLow) begin
                low_d   = bus.byte_i;
                state_d = PkHigh;
            end else begin
                state_d = PkLow;
                if (fifo_full && !pop) begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= PkLow;
            low_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            low_q      <= low_d;
            overflow_q <= overflow_d;
        end
    end

    tiny_nn_fifo #(
        .Width ($bits(fp_t)),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push),
        .wdata_i (packed_word),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .level_o (fifo_level),
        .full_o  (fifo_full)
    );

`ifdef TINY_NN_OUT_PACK_NAN_FLAG_EN
    logic nan_seen_q, nan_seen_d;

    // Any completed NaN word sets the flag, whether it was pushed or dropped.
    always_comb begin
        nan_seen_d = nan_seen_q;
        if (clear_i) begin
            nan_seen_d = 1'b0;
        end else if (high_accept && (packed_word == FPStdNaN)) begin
            nan_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nan_seen_q <= 1'b0;
        end else begin
            nan_seen_q <= nan_seen_d;
        end
    end

    assign nan_seen_o = nan_seen_q;
`else
    assign nan_seen_o = 1'b0;
`endif

    assign bus.word_valid_o = (fifo_level != '0);
    assign bus.word_o       = fifo_rdata;
    assign level_o          = fifo_level;
    assign half_word_o      = (state_q == PkHigh);
    assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_tiny_nn_out_pack.sv
// tb_tiny_nn_out_pack: directed self-checking bench for tiny_nn_out_pack.
// Each scenario task drives its own bytes and checks outputs 1 time unit
// after the rising edge. Define TINY_NN_OUT_PACK_NAN_FLAG_EN to match the DUT build.
module tb_tiny_nn_out_pack;

`ifdef TINY_NN_OUT_PACK_NAN_FLAG_EN
    localparam bit NanEn = 1'b1;
`else
    localparam bit NanEn = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [2:0] level;
    logic       half_word;
    logic       overflow;
    logic       nan_seen;
    int         errors;
    int         checks;

    tiny_nn_out_pack_if bus ();

    tiny_nn_out_pack dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .bus         (bus),
        .level_o     (level),
        .half_word_o (half_word),
        .overflow_o  (overflow),
        .nan_seen_o  (nan_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one valid byte for exactly one cycle.
    task automatic send_byte(input logic [7:0] b);
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = b;
        step();
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = 8'h00;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (bus.word_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.word_valid_o); end
        checks++; if (bus.word_o !== 16'h0000) begin errors++; $display("[TB] FAIL reset_word got=%h exp=0000", bus.word_o); end
        checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
        checks++; if (half_word !== 1'b0) begin errors++; $display("[TB] FAIL reset_half got=%b exp=0", half_word); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (nan_seen !== 1'b0) begin errors++; $display("[TB] FAIL reset_nan got=%b exp=0", nan_seen); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_pack();
        bus.word_ready_i = 1'b0;
        send_byte(8'h34);
        checks++; if (half_word !== 1'b1) begin errors++; $display("[TB] FAIL basic_half got=%b exp=1", half_word); end
        checks++; if (bus.word_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid got=%b exp=0", bus.word_valid_o); end
        send_byte(8'h12);
        checks++; if (bus.word_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got=%b exp=1", bus.word_valid_o); end
        checks++; if (bus.word_o !== 16'h1234) begin errors++; $display("[TB] FAIL basic_word got=%h exp=1234", bus.word_o); end
        checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL basic_level got=%0d exp=1", level); end
        checks++; if (half_word !== 1'b0) begin errors++; $display("[TB] FAIL basic_half_done got=%b exp=0", half_word); end
        bus.word_ready_i = 1'b1;
        step();
        bus.word_ready_i = 1'b0;
        checks++; if (bus.word_valid_o !== 1'b0 || bus.word_o !== 16'h0000) begin errors++; $display("[TB] FAIL basic_drain valid=%b word=%h exp valid=0 word=0000", bus.word_valid_o, bus.word_o); end
        // Ready while empty must not disturb the level.
        bus.word_ready_i = 1'b1;
        step();
        bus.word_ready_i = 1'b0;
        checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL empty_pop_level got=%0d exp=0", level); end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_words [4];
        exp_words = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        bus.word_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i));
            send_byte(8'h00);
        end
        checks++; if (level !== 3'd4 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_fill level=%0d ovf=%b exp level=4 ovf=0", level, overflow); end
        send_byte(8'hAA);
        send_byte(8'hBB);
        checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL ovf_level got=%0d exp=4", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (half_word !== 1'b0) begin errors++; $display("[TB] FAIL ovf_realign got=%b exp=0", half_word); end
        bus.word_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.word_valid_o !== 1'b1 || bus.word_o !== exp_words[i]) begin errors++; $display("[TB] FAIL ovf_drain%0d valid=%b word=%h exp valid=1 word=%h", i, bus.word_valid_o, bus.word_o, exp_words[i]); end
            step();
        end
        bus.word_ready_i = 1'b0;
        checks++; if (bus.word_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_empty got=%b exp=0", bus.word_valid_o); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got=%b exp=1", overflow); end
        do_clear();
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp_words [4];
        exp_words = '{16'h0002, 16'h0003, 16'h0004, 16'h5678};
        bus.word_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i));
            send_byte(8'h00);
        end
        send_byte(8'h78);
        checks++; if (bus.word_o !== 16'h0001) begin errors++; $display("[TB] FAIL fullpop_head got=%h exp=0001", bus.word_o); end
        bus.word_ready_i = 1'b1;
        send_byte(8'h56);
        bus.word_ready_i = 1'b0;
        checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL fullpop_level got=%0d exp=4", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_ovf got=%b exp=0", overflow); end
        bus.word_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.word_o !== exp_words[i]) begin errors++; $display("[TB] FAIL fullpop_drain%0d got=%h exp=%h", i, bus.word_o, exp_words[i]); end
            step();
        end
        bus.word_ready_i = 1'b0;
        checks++; if (bus.word_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_empty got=%b exp=0", bus.word_valid_o); end
    endtask

    task automatic test_clear();
        bus.word_ready_i = 1'b0;
        send_byte(8'h34);
        clear = 1'b1;
        send_byte(8'h12);
        clear = 1'b0;
        checks++; if (half_word !== 1'b0 || level !== 3'd0) begin errors++; $display("[TB] FAIL clear_state half=%b level=%0d exp half=0 level=0", half_word, level); end
        checks++; if (overflow !== 1'b0 || nan_seen !== 1'b0) begin errors++; $display("[TB] FAIL clear_flags ovf=%b nan=%b exp 0 0", overflow, nan_seen); end
        send_byte(8'h78);
        send_byte(8'h56);
        checks++; if (bus.word_o !== 16'h5678 || level !== 3'd1) begin errors++; $display("[TB] FAIL clear_after word=%h level=%0d exp word=5678 level=1", bus.word_o, level); end
        do_clear();
    endtask

    task automatic test_back_to_back();
        bus.word_ready_i = 1'b1;
        send_byte(8'h11);
        send_byte(8'h22);
        checks++; if (bus.word_valid_o !== 1'b1 || bus.word_o !== 16'h2211) begin errors++; $display("[TB] FAIL b2b_first valid=%b word=%h exp valid=1 word=2211", bus.word_valid_o, bus.word_o); end
        send_byte(8'h33);
        checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL b2b_pop level=%0d exp=0", level); end
        send_byte(8'h44);
        checks++; if (bus.word_o !== 16'h4433 || level !== 3'd1) begin errors++; $display("[TB] FAIL b2b_second word=%h level=%0d exp word=4433 level=1", bus.word_o, level); end
        step();
        bus.word_ready_i = 1'b0;
        checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL b2b_drain level=%0d exp=0", level); end
    endtask

    task automatic test_reset_midword();
        bus.word_ready_i = 1'b0;
        send_byte(8'hCD);
        rst_n = 1'b0;
        #2;
        checks++; if (half_word !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_half got=%b exp=0", half_word); end
        rst_n = 1'b1;
        step();
        send_byte(8'h01);
        send_byte(8'h02);
        checks++; if (bus.word_o !== 16'h0201 || level !== 3'd1) begin errors++; $display("[TB] FAIL rstmid_word word=%h level=%0d exp word=0201 level=1", bus.word_o, level); end
        do_clear();
    endtask

    task automatic test_nan_flag();
        bus.word_ready_i = 1'b0;
        send_byte(8'h00);
        send_byte(8'h7E);
        checks++; if (bus.word_o !== 16'h7E00) begin errors++; $display("[TB] FAIL nan_word got=%h exp=7e00", bus.word_o); end
        checks++; if (nan_seen !== NanEn) begin errors++; $display("[TB] FAIL nan_set got=%b exp=%b", nan_seen, NanEn); end
        // Non-NaN word afterwards must not clear the sticky flag.
        send_byte(8'h01);
        send_byte(8'h00);
        step();
        checks++; if (nan_seen !== NanEn) begin errors++; $display("[TB] FAIL nan_hold got=%b exp=%b", nan_seen, NanEn); end
        do_clear();
        checks++; if (nan_seen !== 1'b0) begin errors++; $display("[TB] FAIL nan_clear got=%b exp=0", nan_seen); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        errors           = 0;
        checks           = 0;
        rst_n            = 1'b1;
        clear            = 1'b0;
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = 8'h00;
        bus.word_ready_i = 1'b0;
        test_reset();
        test_basic_pack();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_back_to_back();
        test_reset_midword();
        test_nan_flag();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
